// File: rtl/memctl_master_if.sv
// Request/response and byte-wide memctl signals of memctl_master.
// master: the memctl_master side; slave: the CPU/memory side.
interface memctl_master_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    modport master (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/memctl_master.sv
// Splits byte/half/word load-store requests into little-endian byte accesses on memctl.
// Optional MEMCTL_MASTER_ALIGN_CHECK_EN: misaligned requests are rejected with rsp_err.
module memctl_master #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic            clk,
    input  logic            rst,
    memctl_master_if.master bus
);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;
    state_t state, state_nxt;

    logic [1:0]        idx, idx_nxt, n_last, n_last_nxt, cap_idx, cap_idx_nxt, idx_inc_c;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [31:0]       wdata_q, wdata_nxt, acc, acc_nxt, asm_c;
    logic              req_ready_q, req_ready_nxt, rsp_valid_q, rsp_valid_nxt;
    logic              rsp_err_q, rsp_err_nxt, mem_we_q, mem_we_nxt;
    logic [31:0]       rsp_rdata_q, rsp_rdata_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [7:0]        mem_wdata_q, mem_wdata_nxt;
    logic              fire_c, err_c, cap_c;
    logic [1:0]        req_last_c;
    logic [ADDR_W:0]   end_addr_c;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;

    // Request decode: byte count and range check at ADDR_W+1 bits so the end address cannot wrap.
    always_comb begin
        fire_c = bus.req_valid & req_ready_q;
        case (bus.req_size)
            2'd1:    req_last_c = 2'd1;
            2'd2:    req_last_c = 2'd3;
            default: req_last_c = 2'd0;
        endcase
        end_addr_c = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_last_c);
        err_c      = (bus.req_size == 2'd3) || (end_addr_c > LAST_ADDR);
`ifdef MEMCTL_MASTER_ALIGN_CHECK_EN
        if ((bus.req_addr[1:0] & req_last_c) != 2'd0) err_c = 1'b1;
`endif
    end

    // Read data trails the address by one cycle; DRAIN catches the last byte.
    always_comb begin
        cap_c = ((state == READ) && (idx != 2'd0)) || (state == DRAIN);
        asm_c = acc;
        if (cap_c) asm_c[{cap_idx, 3'b000} +: 8] = bus.mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire_c) state_nxt = err_c ? RESP : (bus.req_write ? WRITE : READ);
            WRITE:   if (idx == n_last) state_nxt = RESP;
            READ:    if (idx == n_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Computes next-cycle values of all registered outputs and the request context.
    always_comb begin
        idx_inc_c     = idx + 2'd1;
        idx_nxt       = idx;
        n_last_nxt    = n_last;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        acc_nxt       = asm_c;
        cap_idx_nxt   = cap_idx + {1'b0, cap_c};
        req_ready_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = rsp_rdata_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        mem_we_nxt    = 1'b0;
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (fire_c) begin
                    req_ready_nxt = 1'b0;
                    idx_nxt       = 2'd0;
                    n_last_nxt    = req_last_c;
                    addr_nxt      = bus.req_addr;
                    wdata_nxt     = bus.req_wdata;
                    acc_nxt       = 32'd0;
                    cap_idx_nxt   = 2'd0;
                    if (err_c) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                    end else begin
                        mem_addr_nxt = bus.req_addr;
                        mem_we_nxt   = bus.req_write;
                        if (bus.req_write) mem_wdata_nxt = bus.req_wdata[7:0];
                    end
                end
            end
            WRITE, READ: begin
                if (idx != n_last) begin
                    idx_nxt      = idx_inc_c;
                    mem_addr_nxt = addr_q + ADDR_W'(idx_inc_c);
                    if (state == WRITE) begin
                        mem_we_nxt    = 1'b1;
                        mem_wdata_nxt = wdata_q[{idx_inc_c, 3'b000} +: 8];
                    end
                end else if (state == WRITE) begin
                    rsp_valid_nxt = 1'b1;
                end
            end
            DRAIN: begin
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = asm_c;
            end
            RESP:    req_ready_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= 2'd0;
            n_last      <= 2'd0;
            cap_idx     <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            acc         <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            n_last      <= n_last_nxt;
            cap_idx     <= cap_idx_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            acc         <= acc_nxt;
            req_ready_q <= req_ready_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_err_q   <= rsp_err_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            mem_we_q    <= mem_we_nxt;
        end
    end
endmodule

// File: tb/tb_memctl_master.sv
// Directed bench for memctl_master against a 1-cycle registered-read byte memory.
module tb_memctl_master;
    localparam int unsigned ADDR_W = 17;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;
    int          we_cnt   = 0;
    int          rsp_cnt  = 0;
    int          we0, rsp0;
    logic [31:0] last_rdata;
    logic [7:0]  mem [0:65535];

    memctl_master_if #(.ADDR_W(ADDR_W)) bus ();
    memctl_master #(.ADDR_W(ADDR_W), .MEM_BYTES(65536)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // memctl stand-in: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[15:0]] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        bus.mem_rdata <= mem[bus.mem_addr[15:0]];
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request in cycle 0 and returns sampling in cycle 1.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [16:0] a, input logic [31:0] d);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [16:0] a, input logic [1:0] sz, input logic [31:0] d, input int n);
        logic [31:0] dv;
        dv = d;
        issue(1'b1, sz, a, d);
        for (int k = 0; k < n; k++) begin
            chk("st_we", 32'(bus.mem_we), 32'd1);
            chk("st_addr", 32'(bus.mem_addr), 32'(a) + 32'(k));
            chk("st_wdata", 32'(bus.mem_wdata), 32'(dv[8*k +: 8]));
            chk("st_rsp_early", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("st_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("st_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("st_rdata_held", bus.rsp_rdata, last_rdata);
        chk("st_we_off", 32'(bus.mem_we), 32'd0);
        tick();
        chk("st_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_load(input logic [16:0] a, input logic [1:0] sz, input int n, input logic [31:0] exp);
        issue(1'b0, sz, a, 32'hDEAD_BEEF);
        for (int k = 0; k < n; k++) begin
            chk("ld_we", 32'(bus.mem_we), 32'd0);
            chk("ld_addr", 32'(bus.mem_addr), 32'(a) + 32'(k));
            tick();
        end
        chk("ld_drain_quiet", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("ld_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("ld_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("ld_rdata", bus.rsp_rdata, exp);
        last_rdata = exp;
        tick();
        chk("ld_ready_back", 32'(bus.req_ready), 32'd1);
        chk("ld_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_err(input logic w, input logic [1:0] sz, input logic [16:0] a, input logic [31:0] d);
        int w0;
        w0 = we_cnt;
        issue(w, sz, a, d);
        chk("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("err_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("err_rdata_held", bus.rsp_rdata, last_rdata);
        chk("err_we", 32'(bus.mem_we), 32'd0);
        tick();
        chk("err_ready_back", 32'(bus.req_ready), 32'd1);
        chk("err_no_write", 32'(we_cnt - w0), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = '0;
        bus.req_wdata = 32'd0;
        last_rdata    = 32'd0;
        repeat (2) tick();
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'd1);

        // Word store then word/byte loads
        do_store(17'h00010, 2'd2, 32'h1122_3344, 4);
        chk("mem_10", 32'(mem[16'h0010]), 32'h44);
        chk("mem_11", 32'(mem[16'h0011]), 32'h33);
        chk("mem_12", 32'(mem[16'h0012]), 32'h22);
        chk("mem_13", 32'(mem[16'h0013]), 32'h11);
        do_load(17'h00010, 2'd2, 4, 32'h1122_3344);
        do_load(17'h00012, 2'd0, 1, 32'h0000_0022);

        // Top-of-memory boundary
        do_err(1'b0, 2'd2, 17'h0FFFE, 32'd0);
        do_store(17'h0FFFF, 2'd0, 32'h0000_00A5, 1);
        do_load(17'h0FFFF, 2'd0, 1, 32'h0000_00A5);
        do_err(1'b0, 2'd0, 17'h10000, 32'd0);

        // Misaligned half store
`ifdef MEMCTL_MASTER_ALIGN_CHECK_EN
        do_err(1'b1, 2'd1, 17'h00003, 32'h0000_BEEF);
`else
        do_store(17'h00003, 2'd1, 32'h0000_BEEF, 2);
        chk("mem_03", 32'(mem[16'h0003]), 32'hEF);
        chk("mem_04", 32'(mem[16'h0004]), 32'hBE);
        do_load(17'h00003, 2'd1, 2, 32'h0000_BEEF);
`endif

        // Illegal size
        do_err(1'b1, 2'd3, 17'h00000, 32'h1234_5678);

        // Back-to-back with req_valid held: store byte, then load it
        chk("b2b_ready0", 32'(bus.req_ready), 32'd1);
        bus.req_write = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_addr  = 17'h00020;
        bus.req_wdata = 32'h0000_005A;
        bus.req_valid = 1'b1;
        tick();
        bus.req_write = 1'b0;
        chk("b2b_busy1", 32'(bus.req_ready), 32'd0);
        chk("b2b_we", 32'(bus.mem_we), 32'd1);
        chk("b2b_wdata", 32'(bus.mem_wdata), 32'h5A);
        tick();
        chk("b2b_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_busy2", 32'(bus.req_ready), 32'd0);
        tick();
        chk("b2b_ready_back", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_ld_busy", 32'(bus.req_ready), 32'd0);
        chk("b2b_ld_we", 32'(bus.mem_we), 32'd0);
        chk("b2b_ld_addr", 32'(bus.mem_addr), 32'h20);
        tick();
        chk("b2b_ld_drain", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("b2b_ld_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_ld_rdata", bus.rsp_rdata, 32'h0000_005A);
        tick();

        // Reset in cycle 2 of a word store
        we0  = we_cnt;
        rsp0 = rsp_cnt;
        issue(1'b1, 2'd2, 17'h00040, 32'hCAFE_F00D);
        chk("mr_we_c1", 32'(bus.mem_we), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("mr_we_off", 32'(bus.mem_we), 32'd0);
        chk("mr_addr_off", 32'(bus.mem_addr), 32'd0);
        chk("mr_wdata_off", 32'(bus.mem_wdata), 32'd0);
        chk("mr_rsp_off", 32'(bus.rsp_valid), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("mr_ready", 32'(bus.req_ready), 32'd1);
        chk("mr_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
        chk("mr_one_write", 32'(we_cnt - we0), 32'd1);
        chk("mr_mem_40", 32'(mem[16'h0040]), 32'h0D);
        last_rdata = 32'd0;
        do_load(17'h00040, 2'd0, 1, 32'h0000_000D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
